// File: rtl/flight_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flight_pkg
//  Description : Shared constants, the Q16.16 operand type and the step
//                sequencer state encoding for the flight simulation datapath.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package flight_pkg;

  localparam int FLIGHT_DATA_WIDTH     = 32;      // Q16.16 velocity width
  localparam int FLIGHT_INPUT_WIDTH    = 8;       // pitch/roll/throttle width
  localparam int FLIGHT_TICK_CYCLES    = 833333;  // 60 Hz at 50 MHz
  localparam int FLIGHT_TIMEOUT_CYCLES = 65536;   // watchdog limit

  // Signed Q16.16 fixed point: 16 integer bits, 16 fractional bits.
  typedef logic signed [FLIGHT_DATA_WIDTH-1:0] q16_16_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_IN_RDY   = 3'd2,
    ST_VEL_WAIT = 3'd3,
    ST_VEL_RDY  = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/sim_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sim_tick_gen
//  Description : Free-running simulation tick generator. Counts
//                0..TICK_CYCLES-1 while run_en is high and asserts tick for
//                one cycle on the last count. Held at 0 while run_en is low.
//  Ports       : clk    in  system clock
//                reset  in  synchronous, active-high
//                run_en in  1 = count
//                tick   out 1-cycle pulse every TICK_CYCLES cycles
//  Revision    : 1.0  initial release
// ============================================================================
module sim_tick_gen
  import flight_pkg::*;
#(
  parameter int TICK_CYCLES = FLIGHT_TICK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic run_en,
  output logic tick
);

  localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || !run_en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = run_en && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/flight_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : flight_step_sequencer
//  Description : Fixed-rate scheduler for one plane_state simulation step.
//                Launches a step on each sim tick, serves the pilot-input and
//                velocity handshakes of plane_state, and presents latched,
//                stable operands. Counts completed steps and dropped ticks.
//  Config      : FLIGHT_SEQ_WATCHDOG_EN - when defined, a step still busy
//                after TIMEOUT_CYCLES cycles is aborted and timeout is set.
//  Ports       : clk, reset                  clock, sync active-high reset
//                run_en                      launch steps on ticks
//                pilot_pitch/roll/throttle   raw pilot inputs
//                update_enable, update_done  step window / completion pulse
//                request_input, input_ready  pilot-input handshake
//                pitch_change/roll_change/throttle  latched pilot inputs
//                request_velocities, velocities_ready  velocity handshake
//                vel_start, vel_done, vel_*_in  velocity unit interface
//                v_x/v_y/v_z                 latched velocities
//                busy, step_done             status
//                frame_count, overrun_count  step / dropped-tick counters
//                proto_err, timeout          sticky error flags
//  Revision    : 1.0  initial release
// ============================================================================
module flight_step_sequencer
  import flight_pkg::*;
#(
  parameter int DATA_WIDTH     = FLIGHT_DATA_WIDTH,
  parameter int INPUT_WIDTH    = FLIGHT_INPUT_WIDTH,
  parameter int TICK_CYCLES    = FLIGHT_TICK_CYCLES,
  parameter int TIMEOUT_CYCLES = FLIGHT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run_en,
  input  logic [INPUT_WIDTH-1:0] pilot_pitch,
  input  logic [INPUT_WIDTH-1:0] pilot_roll,
  input  logic [INPUT_WIDTH-1:0] pilot_throttle,
  output logic                   update_enable,
  input  logic                   update_done,
  input  logic                   request_input,
  output logic                   input_ready,
  output logic [INPUT_WIDTH-1:0] pitch_change,
  output logic [INPUT_WIDTH-1:0] roll_change,
  output logic [INPUT_WIDTH-1:0] throttle,
  input  logic                   request_velocities,
  output logic                   velocities_ready,
  output logic                   vel_start,
  input  logic                   vel_done,
  input  logic [DATA_WIDTH-1:0]  vel_x_in,
  input  logic [DATA_WIDTH-1:0]  vel_y_in,
  input  logic [DATA_WIDTH-1:0]  vel_z_in,
  output logic [DATA_WIDTH-1:0]  v_x,
  output logic [DATA_WIDTH-1:0]  v_y,
  output logic [DATA_WIDTH-1:0]  v_z,
  output logic                   busy,
  output logic                   step_done,
  output logic [15:0]            frame_count,
  output logic [7:0]             overrun_count,
  output logic                   proto_err,
  output logic                   timeout
);

  seq_state_t state, state_next;

  logic tick;
  logic launch;       // IDLE -> RUN this edge
  logic latch_in;     // capture pilot inputs this edge
  logic latch_vel;    // capture velocity results this edge
  logic start_vel;    // issue vel_start next cycle
  logic complete;     // step finishes this edge
  logic proto_hit;
  logic overrun_hit;
  logic wd_expire;

  sim_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .run_en (run_en),
    .tick   (tick)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and per-edge strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    latch_in   = 1'b0;
    latch_vel  = 1'b0;
    start_vel  = 1'b0;
    complete   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (tick) begin
          launch     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Completion wins over both requests; input is served before velocity.
        if (update_done) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end else if (request_input) begin
          latch_in   = 1'b1;
          state_next = ST_IN_RDY;
        end else if (request_velocities) begin
          start_vel  = 1'b1;
          state_next = ST_VEL_WAIT;
        end
      end
      ST_IN_RDY: begin
        if (!request_input) begin
          state_next = ST_RUN;
        end
      end
      ST_VEL_WAIT: begin
        if (vel_done) begin
          latch_vel  = 1'b1;
          state_next = ST_VEL_RDY;
        end
      end
      ST_VEL_RDY: begin
        if (!request_velocities) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Watchdog abort overrides any progress made this cycle.
    if (wd_expire) begin
      state_next = ST_IDLE;
      latch_in   = 1'b0;
      latch_vel  = 1'b0;
      start_vel  = 1'b0;
      complete   = 1'b0;
    end
  end

  assign proto_hit   = (update_done && (state != ST_RUN)) ||
                       (vel_done && (state != ST_VEL_WAIT));
  assign overrun_hit = tick && (state != ST_IDLE);

  // Level outputs follow the registered state directly.
  assign busy             = (state != ST_IDLE);
  assign update_enable    = (state != ST_IDLE);
  assign input_ready      = (state == ST_IN_RDY);
  assign velocities_ready = (state == ST_VEL_RDY);

  // --------------------------------------------------------------------------
  // Operand latches, pulses and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pitch_change  <= '0;
      roll_change   <= '0;
      throttle      <= '0;
      v_x           <= '0;
      v_y           <= '0;
      v_z           <= '0;
      vel_start     <= 1'b0;
      step_done     <= 1'b0;
      frame_count   <= '0;
      overrun_count <= '0;
      proto_err     <= 1'b0;
    end else begin
      if (latch_in) begin
        pitch_change <= pilot_pitch;
        roll_change  <= pilot_roll;
        throttle     <= pilot_throttle;
      end
      if (latch_vel) begin
        v_x <= vel_x_in;
        v_y <= vel_y_in;
        v_z <= vel_z_in;
      end
      vel_start <= start_vel;
      step_done <= complete;
      if (complete) begin
        frame_count <= frame_count + 16'd1;
      end
      if (overrun_hit && (overrun_count != 8'hFF)) begin
        overrun_count <= overrun_count + 8'd1;
      end
      if (proto_hit) begin
        proto_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional step watchdog
  // --------------------------------------------------------------------------
`ifdef FLIGHT_SEQ_WATCHDOG_EN
  localparam int             WDW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [WDW-1:0] wd_count;
  logic           timeout_flag;

  // wd_count holds the number of busy cycles already elapsed, so expiry on
  // WD_LAST keeps the step window exactly TIMEOUT_CYCLES cycles long.
  assign wd_expire = (state != ST_IDLE) && (wd_count == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_count     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (launch) begin
        wd_count <= '0;
      end else if (state != ST_IDLE) begin
        wd_count <= wd_count + WDW'(1);
      end
      if (wd_expire) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  assign timeout = timeout_flag;
`else
  logic unused_timeout_cfg;
  logic unused_launch;

  assign wd_expire          = 1'b0;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign unused_launch      = launch;
`endif

endmodule
`default_nettype wire
